// File: rtl/psram_pkg.sv
// Shared constants, state encoding and port ids for the PSRAM64 two-port arbiter.
// Defaults describe an 8 MB part with 1 KB pages and a 256-byte CE# low-time bound.
package psram_pkg;

    localparam int DEF_ADDR_W      = 23;
    localparam int DEF_LEN_W       = 12;
    localparam int DEF_MAX_BURST   = 256;
    localparam int DEF_PAGE_BYTES  = 1024;
    localparam int DEF_TIMEOUT_CYC = 4096;
    localparam int CMD_LEN_W       = 9;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_WAIT   = 2'd2,
        ST_FINISH = 2'd3
    } arb_state_e;

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

endpackage

// File: rtl/psram_burst_splitter.sv
// Combinational burst sizing: chunk = min(rem, MAX_BURST, bytes left in the current page).
// Only the in-page offset of the address matters, so that is all it takes.
module psram_burst_splitter
    import psram_pkg::*;
#(
    parameter int LEN_W      = DEF_LEN_W,
    parameter int MAX_BURST  = DEF_MAX_BURST,
    parameter int PAGE_BYTES = DEF_PAGE_BYTES,
    parameter int PG_W       = $clog2(PAGE_BYTES)
) (
    input  logic [PG_W-1:0]      page_offs_i,
    input  logic [LEN_W-1:0]     rem_i,
    output logic [CMD_LEN_W-1:0] chunk_o
);

    // One bit wider than the length so a full page (PAGE_BYTES) is representable.
    localparam int CW = LEN_W + 1;

    logic [CW-1:0] room;
    logic [CW-1:0] chunk_w;

    always_comb begin
        room    = CW'(PAGE_BYTES) - CW'(page_offs_i);
        chunk_w = CW'(rem_i);
        if (chunk_w > CW'(MAX_BURST)) begin
            chunk_w = CW'(MAX_BURST);
        end
        if (chunk_w > room) begin
            chunk_w = room;
        end
        chunk_o = CMD_LEN_W'(chunk_w);
    end

endmodule

// File: rtl/psram_arbiter.sv
// Two-port round-robin arbiter that splits each granted transfer into page-safe bursts for PSRAM64.
// gnt is a pulse in the IDLE cycle that accepts a request; done/err are registered pulses after FINISH.
module psram_arbiter
    import psram_pkg::*;
#(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int LEN_W       = DEF_LEN_W,
    parameter int MAX_BURST   = DEF_MAX_BURST,
    parameter int PAGE_BYTES  = DEF_PAGE_BYTES,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic                 SYS_CLK,
    input  logic                 SYS_RSTn,
    input  logic                 req0,
    input  logic                 req1,
    input  logic                 we0,
    input  logic                 we1,
    input  logic [ADDR_W-1:0]    addr0,
    input  logic [ADDR_W-1:0]    addr1,
    input  logic [LEN_W-1:0]     len0,
    input  logic [LEN_W-1:0]     len1,
    output logic                 gnt0,
    output logic                 gnt1,
    output logic                 done0,
    output logic                 done1,
    output logic                 err0,
    output logic                 err1,
    output logic                 cmd_valid,
    output logic                 cmd_we,
    output logic [ADDR_W-1:0]    cmd_addr,
    output logic [CMD_LEN_W-1:0] cmd_len,
    input  logic                 cmd_ready,
    input  logic                 cmd_done,
    output logic                 busy
);

    localparam int PG_W  = $clog2(PAGE_BYTES);
    localparam int TMO_W = $clog2(TIMEOUT_CYC);

    arb_state_e          state_q, state_d;
    logic                rr_last_q, rr_last_d;
    logic                owner_q, owner_d;
    logic                cur_we_q, cur_we_d;
    logic [ADDR_W-1:0]   cur_addr_q, cur_addr_d;
    logic [LEN_W-1:0]    rem_q, rem_d;
    logic [TMO_W-1:0]    tmo_q, tmo_d;
    logic                abort_q, abort_d;
    logic [1:0]          done_q, done_d;
    logic [1:0]          err_q, err_d;
    logic                pick;
    logic [CMD_LEN_W-1:0] chunk;

    psram_burst_splitter #(
        .LEN_W      (LEN_W),
        .MAX_BURST  (MAX_BURST),
        .PAGE_BYTES (PAGE_BYTES),
        .PG_W       (PG_W)
    ) u_splitter (
        .page_offs_i (cur_addr_q[PG_W-1:0]),
        .rem_i       (rem_q),
        .chunk_o     (chunk)
    );

    always_ff @(posedge SYS_CLK or negedge SYS_RSTn) begin
        if (!SYS_RSTn) begin
            state_q    <= ST_IDLE;
            rr_last_q  <= PORT1;
            owner_q    <= PORT0;
            cur_we_q   <= 1'b0;
            cur_addr_q <= '0;
            rem_q      <= '0;
            tmo_q      <= '0;
            abort_q    <= 1'b0;
            done_q     <= '0;
            err_q      <= '0;
        end else begin
            state_q    <= state_d;
            rr_last_q  <= rr_last_d;
            owner_q    <= owner_d;
            cur_we_q   <= cur_we_d;
            cur_addr_q <= cur_addr_d;
            rem_q      <= rem_d;
            tmo_q      <= tmo_d;
            abort_q    <= abort_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    // On a tie the port that did not win last time gets the grant.
    assign pick = (req0 && req1) ? ~rr_last_q : req1;

    always_comb begin
        state_d    = state_q;
        rr_last_d  = rr_last_q;
        owner_d    = owner_q;
        cur_we_d   = cur_we_q;
        cur_addr_d = cur_addr_q;
        rem_d      = rem_q;
        tmo_d      = tmo_q;
        abort_d    = abort_q;
        done_d     = '0;
        err_d      = '0;
        gnt0       = 1'b0;
        gnt1       = 1'b0;
        cmd_valid  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req0 || req1) begin
                    owner_d    = pick;
                    rr_last_d  = pick;
                    cur_we_d   = pick ? we1 : we0;
                    cur_addr_d = pick ? addr1 : addr0;
                    rem_d      = pick ? len1 : len0;
                    gnt0       = ~pick;
                    gnt1       = pick;
                    state_d    = ((pick ? len1 : len0) == '0) ? ST_FINISH : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                cmd_valid = 1'b1;
                if (cmd_ready) begin
                    tmo_d   = '0;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // Completion takes priority over a timeout landing in the same cycle.
                if (cmd_done) begin
                    cur_addr_d = cur_addr_q + ADDR_W'(chunk);
                    rem_d      = rem_q - LEN_W'(chunk);
                    state_d    = (rem_q == LEN_W'(chunk)) ? ST_FINISH : ST_ISSUE;
                end else if (tmo_q == TMO_W'(TIMEOUT_CYC - 1)) begin
                    abort_d = 1'b1;
                    state_d = ST_FINISH;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            ST_FINISH: begin
                done_d  = owner_q ? 2'b10 : 2'b01;
                err_d   = abort_q ? done_d : 2'b00;
                abort_d = 1'b0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign done0    = done_q[0];
    assign done1    = done_q[1];
    assign err0     = err_q[0];
    assign err1     = err_q[1];
    assign cmd_we   = cur_we_q;
    assign cmd_addr = cur_addr_q;
    assign cmd_len  = chunk;
    assign busy     = (state_q != ST_IDLE);

endmodule
